// File: rtl/box_motion_ctrl_pkg.sv
// Purpose : shared types and constants for the box scheduler, timing and pixel generators.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: colour index type, position type, direction-bit indices, scheduler FSM states,
//           default active-area size, reset colours, signed per-axis delta helper.
package box_motion_ctrl_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int POS_W = 12;
  typedef logic [POS_W-1:0] pos_t;

  // Colour index, same palette order as the bar pattern.
  typedef logic [3:0] color_t;

  // Bit positions inside move_dir.
  localparam int DIR_UP     = 0;
  localparam int DIR_DOWN   = 1;
  localparam int DIR_LEFT   = 2;
  localparam int DIR_RIGHT  = 3;
  localparam int DIR_FREEZE = 4;
  localparam int DIR_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_UPD_A = 2'd2,
    ST_UPD_B = 2'd3
  } state_t;

  localparam color_t B1_COLOR_RST = 4'd1;
  localparam color_t B2_COLOR_RST = 4'd9;

  // Opposing requests cancel; a single request yields +/- step.
  function automatic logic signed [12:0] axis_delta(input logic dec,
                                                    input logic inc,
                                                    input logic signed [12:0] step);
    logic signed [12:0] d;
    d = '0;
    if (inc && !dec)      d = step;
    else if (dec && !inc) d = -step;
    return d;
  endfunction

endpackage

// File: rtl/box_step_unit.sv
// Purpose : shared position adder with edge handling for one box (x and y together).
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports   : pos_x_i/pos_y_i current corner, step_i magnitude, dir_i move_dir bits,
//           en_i move enable, pos_x_o/pos_y_o next corner.
// Config  : BOX_WRAP_EN defined -> leaving the range wraps to the opposite limit;
//           undefined -> positions saturate at the limits.
module box_step_unit
  import box_motion_ctrl_pkg::*;
#(
  parameter int X_MAX = DEF_H_ACTIVE - 64,
  parameter int Y_MAX = DEF_V_ACTIVE - 64
) (
  input  logic [POS_W-1:0] pos_x_i,
  input  logic [POS_W-1:0] pos_y_i,
  input  logic [3:0]       step_i,
  input  logic [DIR_W-1:0] dir_i,
  input  logic             en_i,
  output logic [POS_W-1:0] pos_x_o,
  output logic [POS_W-1:0] pos_y_o
);

  localparam logic signed [12:0] X_LIM = 13'(X_MAX);
  localparam logic signed [12:0] Y_LIM = 13'(Y_MAX);

  logic signed [12:0] step_s;
  logic signed [12:0] dx, dy;
  logic signed [12:0] sum_x, sum_y;

  function automatic logic [POS_W-1:0] fit_axis(input logic signed [12:0] v,
                                                input logic signed [12:0] lim);
    logic [POS_W-1:0] r;
`ifdef BOX_WRAP_EN
    if (v < 13'sd0)    r = lim[POS_W-1:0];
    else if (v > lim)  r = '0;
    else               r = v[POS_W-1:0];
`else
    if (v < 13'sd0)    r = '0;
    else if (v > lim)  r = lim[POS_W-1:0];
    else               r = v[POS_W-1:0];
`endif
    return r;
  endfunction

  assign step_s = $signed({9'd0, step_i});

  always_comb begin
    dx = '0;
    dy = '0;
    // Freeze overrides every direction bit.
    if (en_i && !dir_i[DIR_FREEZE]) begin
      dx = axis_delta(dir_i[DIR_LEFT], dir_i[DIR_RIGHT], step_s);
      dy = axis_delta(dir_i[DIR_UP],   dir_i[DIR_DOWN],  step_s);
    end
  end

  assign sum_x   = $signed({1'b0, pos_x_i}) + dx;
  assign sum_y   = $signed({1'b0, pos_y_i}) + dy;
  assign pos_x_o = fit_axis(sum_x, X_LIM);
  assign pos_y_o = fit_axis(sum_y, Y_LIM);

endmodule

// File: rtl/box_motion_ctrl.sv
// Purpose : per-frame position/colour scheduler for the two on-screen boxes.
// Latency : tick in cycle N -> first box updated end of N+2, second end of N+3, busy low in N+4.
// Backpressure: none; a frame tick arriving while busy is dropped.
// Ports   : rfr_clk, reset_n (async active-low), v_sync (active-low), move_box1/2, dColor_box1/2,
//           move_dir[4:0] (up,down,left,right,freeze), speed -> box1_x/y, box2_x/y, box1/2_color, busy.
// Config  : BOX_WRAP_EN selects wrap instead of clamp at the screen edges (inside box_step_unit).
module box_motion_ctrl
  import box_motion_ctrl_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int BOX_W     = 64,
  parameter int BOX_H     = 64,
  parameter int STEP_SLOW = 1,
  parameter int STEP_FAST = 4,
  parameter int B1_X0     = 64,
  parameter int B1_Y0     = 64,
  parameter int B2_X0     = 448,
  parameter int B2_Y0     = 320
) (
  input  logic             rfr_clk,
  input  logic             reset_n,
  input  logic             v_sync,
  input  logic             move_box1,
  input  logic             move_box2,
  input  logic             dColor_box1,
  input  logic             dColor_box2,
  input  logic [DIR_W-1:0] move_dir,
  input  logic             speed,
  output logic [POS_W-1:0] box1_x,
  output logic [POS_W-1:0] box1_y,
  output logic [POS_W-1:0] box2_x,
  output logic [POS_W-1:0] box2_y,
  output logic [3:0]       box1_color,
  output logic [3:0]       box2_color,
  output logic             busy
);

  localparam int         X_MAX  = H_ACTIVE - BOX_W;
  localparam int         Y_MAX  = V_ACTIVE - BOX_H;
  localparam logic [3:0] STEP_S = 4'(STEP_SLOW);
  localparam logic [3:0] STEP_F = 4'(STEP_FAST);
  localparam pos_t       B1_XR  = POS_W'(B1_X0);
  localparam pos_t       B1_YR  = POS_W'(B1_Y0);
  localparam pos_t       B2_XR  = POS_W'(B2_X0);
  localparam pos_t       B2_YR  = POS_W'(B2_Y0);

  // Sequencer state and snapshot of the board controls.
  state_t           state_q;
  logic             busy_q;
  logic             ptr_q;          // 0: box1 is updated first this frame
  logic             mv1_q, mv2_q;
  logic             fast_q;
  logic [DIR_W-1:0] dir_q;

  // Edge detection.
  logic vs_q, vs_prev_q, tick;
  logic dc1_q, dc2_q, rise1, rise2;

  // Box state.
  logic   pend1_q, pend1_d, pend2_q, pend2_d;
  pos_t   b1x_q, b1x_d, b1y_q, b1y_d;
  pos_t   b2x_q, b2x_d, b2y_q, b2y_d;
  color_t c1_q, c1_d, c2_q, c2_d;

  // Shared adder muxing.
  logic in_upd, sel_b2, upd1, upd2;
  pos_t su_x, su_y, su_nx, su_ny;
  logic su_en;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      dc1_q     <= 1'b0;
      dc2_q     <= 1'b0;
    end else begin
      vs_q      <= v_sync;
      vs_prev_q <= vs_q;
      dc1_q     <= dColor_box1;
      dc2_q     <= dColor_box2;
    end
  end

  assign tick  = vs_prev_q & ~vs_q;
  assign rise1 = dColor_box1 & ~dc1_q;
  assign rise2 = dColor_box2 & ~dc2_q;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ptr_q   <= 1'b0;
      mv1_q   <= 1'b0;
      mv2_q   <= 1'b0;
      fast_q  <= 1'b0;
      dir_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_LATCH;
            busy_q  <= 1'b1;
          end
        end
        ST_LATCH: begin
          mv1_q   <= move_box1;
          mv2_q   <= move_box2;
          dir_q   <= move_dir;
          fast_q  <= speed;
          state_q <= ST_UPD_A;
        end
        ST_UPD_A: state_q <= ST_UPD_B;
        ST_UPD_B: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= ~ptr_q;  // alternate order every frame, moved or not
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // UPD_A serves the box named by the pointer, UPD_B the other one.
  assign in_upd = (state_q == ST_UPD_A) || (state_q == ST_UPD_B);
  assign sel_b2 = (state_q == ST_UPD_A) ? ptr_q : ~ptr_q;
  assign upd1   = in_upd & ~sel_b2;
  assign upd2   = in_upd &  sel_b2;

  assign su_x  = sel_b2 ? b2x_q : b1x_q;
  assign su_y  = sel_b2 ? b2y_q : b1y_q;
  assign su_en = sel_b2 ? mv2_q : mv1_q;

  box_step_unit #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_step (
    .pos_x_i (su_x),
    .pos_y_i (su_y),
    .step_i  (fast_q ? STEP_F : STEP_S),
    .dir_i   (dir_q),
    .en_i    (su_en),
    .pos_x_o (su_nx),
    .pos_y_o (su_ny)
  );

  always_comb begin
    b1x_d = b1x_q;
    b1y_d = b1y_q;
    b2x_d = b2x_q;
    b2y_d = b2y_q;
    c1_d  = c1_q;
    c2_d  = c2_q;
    if (upd1) begin
      b1x_d = su_nx;
      b1y_d = su_ny;
      if (pend1_q) c1_d = c1_q + 4'd1;
    end
    if (upd2) begin
      b2x_d = su_nx;
      b2y_d = su_ny;
      if (pend2_q) c2_d = c2_q + 4'd1;
    end
    // A rise in the consume cycle re-arms the flag for the next frame.
    pend1_d = (pend1_q & ~upd1) | rise1;
    pend2_d = (pend2_q & ~upd2) | rise2;
  end

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      b1x_q   <= B1_XR;
      b1y_q   <= B1_YR;
      b2x_q   <= B2_XR;
      b2y_q   <= B2_YR;
      c1_q    <= B1_COLOR_RST;
      c2_q    <= B2_COLOR_RST;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
    end else begin
      b1x_q   <= b1x_d;
      b1y_q   <= b1y_d;
      b2x_q   <= b2x_d;
      b2y_q   <= b2y_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
    end
  end

  assign box1_x     = b1x_q;
  assign box1_y     = b1y_q;
  assign box2_x     = b2x_q;
  assign box2_y     = b2y_q;
  assign box1_color = c1_q;
  assign box2_color = c2_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Purpose : directed self-checking bench for box_motion_ctrl with an expected-state scoreboard.
// Latency : checks the tick -> N+2 / N+3 / N+4 update timing every frame.
// Backpressure: n/a.
module tb_box_motion_ctrl;

  logic        rfr_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_sync = 1'b1;
  logic        move_box1 = 1'b0;
  logic        move_box2 = 1'b0;
  logic        dColor_box1 = 1'b0;
  logic        dColor_box2 = 1'b0;
  logic [4:0]  move_dir = 5'd0;
  logic        speed = 1'b0;
  logic [11:0] box1_x, box1_y, box2_x, box2_y;
  logic [3:0]  box1_color, box2_color;
  logic        busy;

  int total = 0;
  int bad = 0;

  localparam int XL = 640 - 64;
  localparam int YL = 480 - 64;

  always #5 rfr_clk = ~rfr_clk;

  box_motion_ctrl dut (
    .rfr_clk     (rfr_clk),
    .reset_n     (reset_n),
    .v_sync      (v_sync),
    .move_box1   (move_box1),
    .move_box2   (move_box2),
    .dColor_box1 (dColor_box1),
    .dColor_box2 (dColor_box2),
    .move_dir    (move_dir),
    .speed       (speed),
    .box1_x      (box1_x),
    .box1_y      (box1_y),
    .box2_x      (box2_x),
    .box2_y      (box2_y),
    .box1_color  (box1_color),
    .box2_color  (box2_color),
    .busy        (busy)
  );

  typedef struct {
    int x1; int y1; int x2; int y2; int c1; int c2;
  } snap_t;

  snap_t exp_q[$];
  snap_t m;
  bit    mp1, mp2, mptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_snap(input string tag);
    snap_t e;
    e = exp_q.pop_front();
    chk({tag, ".x1"}, 32'(box1_x), e.x1);
    chk({tag, ".y1"}, 32'(box1_y), e.y1);
    chk({tag, ".x2"}, 32'(box2_x), e.x2);
    chk({tag, ".y2"}, 32'(box2_y), e.y2);
    chk({tag, ".c1"}, 32'(box1_color), e.c1);
    chk({tag, ".c2"}, 32'(box2_color), e.c2);
  endtask

  function automatic void model_reset();
    m = '{x1: 64, y1: 64, x2: 448, y2: 320, c1: 1, c2: 9};
    mp1 = 1'b0;
    mp2 = 1'b0;
    mptr = 1'b0;
  endfunction

  function automatic int fit(input int v, input int lim);
`ifdef BOX_WRAP_EN
    if (v < 0) return lim;
    if (v > lim) return 0;
    return v;
`else
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
`endif
  endfunction

  function automatic void apply(input int b, input bit mv, input logic [4:0] d, input bit spd);
    int st, dx, dy;
    st = spd ? 4 : 1;
    dx = 0;
    dy = 0;
    if (mv && !d[4]) begin
      if (d[3] && !d[2]) dx = st;
      else if (d[2] && !d[3]) dx = -st;
      if (d[1] && !d[0]) dy = st;
      else if (d[0] && !d[1]) dy = -st;
    end
    if (b == 1) begin
      m.x1 = fit(m.x1 + dx, XL);
      m.y1 = fit(m.y1 + dy, YL);
      if (mp1) begin m.c1 = (m.c1 + 1) % 16; mp1 = 1'b0; end
    end else begin
      m.x2 = fit(m.x2 + dx, XL);
      m.y2 = fit(m.y2 + dy, YL);
      if (mp2) begin m.c2 = (m.c2 + 1) % 16; mp2 = 1'b0; end
    end
  endfunction

  // n rising edges on the chosen colour input, all before the next tick.
  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rfr_clk);
      if (which == 1) dColor_box1 = 1'b1; else dColor_box2 = 1'b1;
      @(negedge rfr_clk);
      dColor_box1 = 1'b0;
      dColor_box2 = 1'b0;
    end
    if (which == 1) mp1 = 1'b1; else mp2 = 1'b1;
  endtask

  // One v_sync falling edge. late2 raises dColor_box2 in box2's update cycle.
  task automatic frame(input string tag, input bit m1, input bit m2,
                       input logic [4:0] d, input bit spd, input bit late2);
    int busy_n, first_busy, pk;
    bit b2first;
    @(negedge rfr_clk);
    move_box1 = m1;
    move_box2 = m2;
    move_dir  = d;
    speed     = spd;
    b2first = mptr;
    if (b2first) apply(2, m2, d, spd); else apply(1, m1, d, spd);
    exp_q.push_back(m);
    if (b2first) apply(1, m1, d, spd); else apply(2, m2, d, spd);
    exp_q.push_back(m);
    mptr = ~mptr;
    if (late2) mp2 = 1'b1;
    pk = b2first ? 3 : 4;
    v_sync = 1'b0;
    busy_n = 0;
    first_busy = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge rfr_clk);
      if (busy === 1'b1) begin
        busy_n++;
        if (first_busy == 0) first_busy = k;
      end
      if (k == 4) chk_snap({tag, ".mid"});
      if (k == 5) chk_snap({tag, ".end"});
      if (k == 3) begin
        // Controls change after the snapshot; they must not leak into this frame.
        move_box1 = 1'($urandom);
        move_box2 = 1'($urandom);
        move_dir  = 5'($urandom);
        speed     = 1'($urandom);
      end
      if (late2 && k == pk) dColor_box2 = 1'b1;
      if (late2 && k == pk + 1) dColor_box2 = 1'b0;
      if (k == 7) v_sync = 1'b1;
    end
    chk({tag, ".busy_cycles"}, busy_n, 3);
    chk({tag, ".busy_start"}, first_busy, 2);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge rfr_clk);
    chk("rst.x1", 32'(box1_x), 64);
    chk("rst.y1", 32'(box1_y), 64);
    chk("rst.x2", 32'(box2_x), 448);
    chk("rst.y2", 32'(box2_y), 320);
    chk("rst.c1", 32'(box1_color), 1);
    chk("rst.c2", 32'(box2_color), 9);
    chk("rst.busy", 32'(busy), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge rfr_clk);

    // Idle frames: nothing moves, order still alternates.
    for (int i = 0; i < 3; i++) frame("idle", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("idle.x1", 32'(box1_x), 64);
    chk("idle.x2", 32'(box2_x), 448);

    // Box1 right, fast.
    for (int i = 0; i < 10; i++) frame("right", 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0);
    chk("right10.x1", 32'(box1_x), 104);
    chk("right10.y1", 32'(box1_y), 64);
    chk("right10.x2", 32'(box2_x), 448);

    // Walk to the right edge.
    for (int i = 0; i < 117; i++) frame("walk", 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0);
    chk("edge.x1_572", 32'(box1_x), 572);
    frame("edge1", 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0);
    chk("edge.x1_576", 32'(box1_x), 576);
    frame("edge2", 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0);
`ifdef BOX_WRAP_EN
    chk("edge.x1_wrap", 32'(box1_x), 0);
`else
    chk("edge.x1_clamp", 32'(box1_x), 576);
`endif

    // Both boxes moving: left+down fast, then freeze, then left+right+up slow.
    for (int i = 0; i < 4; i++) frame("both", 1'b1, 1'b1, 5'b00110, 1'b1, 1'b0);
    frame("freeze", 1'b1, 1'b1, 5'b11111, 1'b1, 1'b0);
    frame("cancel", 1'b1, 1'b1, 5'b01101, 1'b0, 1'b0);

    // Colour: three edges -> one step; an edge in the consume cycle carries over.
    pulse(2, 3);
    pulse(1, 1);
    frame("col1", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("col.c2_10", 32'(box2_color), 10);
    chk("col.c1_2", 32'(box1_color), 2);
    frame("col2", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("col.c2_11", 32'(box2_color), 11);
    frame("col3", 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("col.c2_hold", 32'(box2_color), 11);

    // Reset while the first update is in progress.
    pulse(1, 1);
    @(negedge rfr_clk);
    move_box1 = 1'b1;
    move_box2 = 1'b1;
    move_dir  = 5'b01010;
    speed     = 1'b1;
    v_sync    = 1'b0;
    repeat (3) @(negedge rfr_clk);
    chk("mid.busy_before_rst", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst.x1", 32'(box1_x), 64);
    chk("arst.y1", 32'(box1_y), 64);
    chk("arst.x2", 32'(box2_x), 448);
    chk("arst.y2", 32'(box2_y), 320);
    chk("arst.c1", 32'(box1_color), 1);
    chk("arst.c2", 32'(box2_color), 9);
    chk("arst.busy", 32'(busy), 0);
    @(negedge rfr_clk);
    v_sync = 1'b1;
    @(negedge rfr_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge rfr_clk);

    // After reset box1 must be served first again and no colour request survives.
    frame("post", 1'b1, 1'b1, 5'b01010, 1'b1, 1'b0);
    frame("post2", 1'b1, 1'b1, 5'b00101, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
